// File: rtl/quad_decoder.sv
// quad_decoder: synchronizes, deglitches and decodes quadrature A/B pins.
// Optional per-channel stability filter: define QUAD_DECODER_FILTER_EN.
module quad_decoder #(
  parameter int FILTER_WIDTH  = 4,
  parameter int FILTER_CYCLES = 8,
  parameter int DECODE_MODE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_enc_a,
  input  logic       quad_enc_b,
  output logic       enc_out,
  output logic       enc_dir,
  output logic       enc_err,
  output logic [1:0] enc_state
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

`ifdef QUAD_DECODER_FILTER_EN
  localparam int INIT_LEN = 2 + FILTER_CYCLES;
`else
  localparam int INIT_LEN = 2;
`endif
  localparam int IW = $clog2(INIT_LEN + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LEN - 1);

  if (!(DECODE_MODE == 1 || DECODE_MODE == 2 || DECODE_MODE == 4) ||
      FILTER_CYCLES < 1 ||
      FILTER_CYCLES > (1 << FILTER_WIDTH) - 1) begin : g_bad_cfg
    $error("quad_decoder: illegal parameter set");
  end

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] init_cnt;
  logic          meta_a;
  logic          meta_b;
  logic          sync_a;
  logic          sync_b;
  logic [1:0]    meta;
  logic [1:0]    syn;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [1:0]    diff;
  logic          fwd;
  logic          qual;
  logic          out_nx;
  logic          err_nx;
  logic          dir_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_a <= 1'b0;
      meta_b <= 1'b0;
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      meta_a <= quad_enc_a;
      meta_b <= quad_enc_b;
      sync_a <= meta_a;
      sync_b <= meta_b;
    end
  end

  assign meta = {meta_a, meta_b};
  assign syn  = {sync_a, sync_b};

`ifdef QUAD_DECODER_FILTER_EN
  localparam logic [FILTER_WIDTH-1:0] FC_LAST =
    FILTER_WIDTH'(FILTER_CYCLES - 1);

  logic [1:0]              filt_q;
  logic [FILTER_WIDTH-1:0] cnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else if (state == INIT) begin
      filt_q <= meta;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syn[i] == filt_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FC_LAST) begin
          filt_q[i] <= syn[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filt = (state == INIT) ? syn : filt_q;
`else
  assign filt = syn;
`endif

  assign enc_state = filt;

  // A-changed parity against prev's A^B tells forward from reverse
  assign diff = prev ^ filt;
  assign fwd  = diff[1] ^ prev[1] ^ prev[0];

  always_comb begin
    qual = 1'b1;
    if (DECODE_MODE == 2) begin
      qual = diff[1];
    end else if (DECODE_MODE == 1) begin
      qual = ~prev[1] & filt[1];
    end
  end

  always_comb begin
    state_nx = state;
    out_nx   = 1'b0;
    err_nx   = 1'b0;
    dir_nx   = enc_dir;
    unique case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        unique case (1'b1)
          (diff == 2'b11): err_nx = 1'b1;
          (diff == 2'b00): ;
          default: begin
            dir_nx = fwd;
            out_nx = qual;
          end
        endcase
      end
      default: state_nx = INIT;
    endcase
  end

  // INIT preloads prev with the value sync takes next, so RUN starts aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      prev     <= 2'b00;
      enc_out  <= 1'b0;
      enc_err  <= 1'b0;
      enc_dir  <= 1'b0;
    end else begin
      state   <= state_nx;
      enc_out <= out_nx;
      enc_err <= err_nx;
      enc_dir <= dir_nx;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        prev     <= meta;
      end else begin
        prev <= filt;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scoreboard bench driving modes 4, 2 and 1 in parallel.
// Expected latency and INIT length follow QUAD_DECODER_FILTER_EN.
module tb_quad_decoder;

`ifdef QUAD_DECODER_FILTER_EN
  localparam int FC   = 8;
  localparam bit FILT = 1'b1;
`else
  localparam int FC   = 0;
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT      = FC + 3;
  localparam int INIT_LEN = FC + 2;

  typedef struct packed {
    int unsigned cyc;
    logic        out;
    logic        err;
    logic        dir;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            quad_enc_a = 1'b0;
  logic            quad_enc_b = 1'b0;
  logic [2:0]      out;
  logic [2:0]      err;
  logic [2:0]      dir;
  logic [2:0][1:0] st;
  int unsigned     cyc = 0;
  int              total = 0;
  int              bad = 0;
  ev_t             sb [3][$];
  logic [1:0]      pins_m = 2'b00;
  logic            dir_m = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_decoder #(.DECODE_MODE(4)) u_m4 (
    .clk(clk), .reset(reset),
    .quad_enc_a(quad_enc_a), .quad_enc_b(quad_enc_b),
    .enc_out(out[0]), .enc_dir(dir[0]),
    .enc_err(err[0]), .enc_state(st[0])
  );

  quad_decoder #(.DECODE_MODE(2)) u_m2 (
    .clk(clk), .reset(reset),
    .quad_enc_a(quad_enc_a), .quad_enc_b(quad_enc_b),
    .enc_out(out[1]), .enc_dir(dir[1]),
    .enc_err(err[1]), .enc_state(st[1])
  );

  quad_decoder #(.DECODE_MODE(1)) u_m1 (
    .clk(clk), .reset(reset),
    .quad_enc_a(quad_enc_a), .quad_enc_b(quad_enc_b),
    .enc_out(out[2]), .enc_dir(dir[2]),
    .enc_err(err[2]), .enc_state(st[2])
  );

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_model(input logic [1:0] c);
    ev_t e;
    bit  f;
    bit  valid;
    bit  q;
    if (c == pins_m) return;
    f     = (c == fwd_next(pins_m));
    valid = f || (pins_m == fwd_next(c));
    for (int m = 0; m < 3; m++) begin
      e.cyc = cyc + LAT;
      if (!valid) begin
        e.out = 1'b0;
        e.err = 1'b1;
        e.dir = dir_m;
        sb[m].push_back(e);
      end else begin
        case (m)
          0:       q = 1'b1;
          1:       q = (pins_m[1] != c[1]);
          default: q = !pins_m[1] && c[1];
        endcase
        if (q) begin
          e.out = 1'b1;
          e.err = 1'b0;
          e.dir = f;
          sb[m].push_back(e);
        end
      end
    end
    if (valid) dir_m = f;
    pins_m = c;
  endtask

  task automatic drive(input logic a, input logic b, input bit track);
    @(posedge clk);
    #1;
    quad_enc_a = a;
    quad_enc_b = b;
    if (track) push_model({a, b});
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every pulse must match the queue head; every due entry must pulse
  ev_t o;
  ev_t x;
  bit  due;
  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 3; m++) begin
        due = sb[m].size() > 0 && sb[m][0].cyc == cyc;
        if (out[m] || err[m] || due) begin
          o.cyc = cyc;
          o.out = out[m];
          o.err = err[m];
          o.dir = dir[m];
          if (due) begin
            x = sb[m].pop_front();
          end else begin
            x.cyc = cyc;
            x.out = 1'b0;
            x.err = 1'b0;
            x.dir = 1'bx;
          end
          total++;
          assert (o === x) else begin
            bad++;
            $error("FAIL ev_m%0d: got cyc=%0d out=%b err=%b dir=%b want cyc=%0d out=%b err=%b dir=%b",
                   m, o.cyc, o.out, o.err, o.dir, x.cyc, x.out, x.err, x.dir);
          end
        end
      end
    end
  end

  initial begin
    // reset held with pins at 11, then released
    quad_enc_a = 1'b1;
    quad_enc_b = 1'b1;
    hold(3);
    #1;
    chk("rst_outs", 16'({out, err, dir}), 16'h0);
    chk("rst_state", 16'(st), 16'h0);
    reset  = 1'b0;
    pins_m = 2'b11;
    dir_m  = 1'b0;
    hold(INIT_LEN + 10);
    @(negedge clk);
    chk("init_state", 16'(st), 16'({3{2'b11}}));

    // forward from 11 down to 00, then a full forward cycle
    drive(0, 1, 1); hold(19);
    drive(0, 0, 1); hold(19);
    drive(1, 0, 1); hold(19);
    drive(1, 1, 1); hold(19);
    drive(0, 1, 1); hold(19);
    drive(0, 0, 1); hold(19);
    @(negedge clk);
    chk("fwd_dir", 16'(dir), 16'h7);

    // reverse cycle
    drive(0, 1, 1); hold(19);
    drive(1, 1, 1); hold(19);
    drive(1, 0, 1); hold(19);
    drive(0, 0, 1); hold(19);
    @(negedge clk);
    chk("rev_dir", 16'(dir), 16'h0);
    chk("rev_state", 16'(st), 16'h0);

    // 5-cycle glitch on A, then a 9-cycle pulse
    drive(1, 0, !FILT);
    hold(2);
    @(negedge clk);
    chk("glitch_state", 16'(st[0]), FILT ? 16'h0 : 16'h2);
    hold(2);
    drive(0, 0, !FILT); hold(19);
    @(negedge clk);
    chk("glitch_after", 16'(st), 16'h0);
    drive(1, 0, 1); hold(8);
    drive(0, 0, 1); hold(19);

    // reach 00 with dir=1, then jump both pins
    drive(0, 1, 1); hold(19);
    drive(0, 0, 1); hold(19);
    drive(1, 1, 1); hold(19);
    @(negedge clk);
    chk("err_state", 16'(st), 16'({3{2'b11}}));
    chk("err_dir", 16'(dir), 16'h7);

    // asynchronous reset mid-sequence
    drive(0, 1, 1); hold(19);
    drive(0, 0, 1); hold(5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_outs", 16'({out, err, dir}), 16'h0);
    chk("arst_state", 16'(st), 16'h0);
    for (int m = 0; m < 3; m++) sb[m].delete();
    quad_enc_a = 1'b1;
    quad_enc_b = 1'b1;
    pins_m = 2'b11;
    dir_m  = 1'b0;
    hold(3);
    #1;
    reset = 1'b0;
    if (INIT_LEN > 2) begin
      hold(INIT_LEN - 2);
      #1;
    end
    // last change INIT can absorb, then the first one RUN must see
    quad_enc_a = 1'b0;
    pins_m     = 2'b01;
    drive(0, 0, 1); hold(19);
    drive(1, 0, 1); hold(19);
    drive(1, 1, 1); hold(19);
    drive(0, 1, 1); hold(19);
    drive(0, 0, 1); hold(19);
    @(negedge clk);
    chk("post_dir", 16'(dir), 16'h7);
    chk("post_state", 16'(st), 16'h0);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("sb_left_m%0d", m), 16'(sb[m].size()), 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
